bnn_infer_sequencer: RTL and testbench

- Controller that sequences one serial BNN classifier core, e.g. the Har bnn1 rospine instance.
- Accepts feature vectors over a valid/ready handshake and holds the core's features stable.
- Pulses the core's reset, waits the fixed hidden+class evaluation window, then captures the prediction and presents it over a second valid/ready handshake.
- Replaces testbench-driven timing so the core can be driven from a streaming source.

---
 rtl/bnn_infer_sequencer_if.sv | 16 +
 rtl/bnn_infer_sequencer.sv | 106 ++++++++++
 tb/tb_bnn_infer_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_infer_sequencer_if.sv
// bnn_infer_sequencer_if: feature-in and result-out valid/ready channels of the BNN sequencer.
interface bnn_infer_sequencer_if #(
  parameter int FEAT_CNT  = 12,
  parameter int FEAT_BITS = 4,
  parameter int CLS_BITS  = 3
);
  logic                          in_valid;
  logic                          in_ready;
  logic [FEAT_CNT*FEAT_BITS-1:0] in_features;
  logic                          out_valid;
  logic                          out_ready;
  logic [CLS_BITS-1:0]           out_class;
  logic                          out_err;
  modport master (output in_valid, in_features, out_ready, input in_ready, out_valid, out_class, out_err);
  modport slave  (input in_valid, in_features, out_ready, output in_ready, out_valid, out_class, out_err);
endinterface

// File: rtl/bnn_infer_sequencer.sv
// bnn_infer_sequencer: drives one serial BNN core (features, reset window, clamped capture).
// Optional one-entry sample prefetch buffer enabled by defining BNN_SEQ_PREFETCH_EN.
module bnn_infer_sequencer #(
  parameter int FEAT_CNT      = 12,
  parameter int FEAT_BITS     = 4,
  parameter int HIDDEN_CNT    = 40,
  parameter int CLASS_CNT     = 6,
  parameter int CLEAR_CYCLES  = 1,
  parameter int SETTLE_CYCLES = HIDDEN_CNT + CLASS_CNT + 1,
  parameter int CLS_BITS      = $clog2(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bnn_infer_sequencer_if.slave          bus,
  output logic [FEAT_CNT*FEAT_BITS-1:0] bnn_features_o,
  output logic                          bnn_rst_o,
  input  logic [CLS_BITS-1:0]           bnn_prediction_i,
  output logic                          busy_o
);
  localparam int CMAX = CLEAR_CYCLES > SETTLE_CYCLES ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;
  state_t                        state_q;
  logic                          armed_q;
  logic [CW-1:0]                 cnt_q;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic                          rst_q;
  logic                          ov_q;
  logic                          err_q;
  logic [CLS_BITS-1:0]           cls_q;
  logic                          take;
  logic                          give;
  logic                          over;
  assign take           = bus.in_valid & bus.in_ready;
  assign give           = ov_q & bus.out_ready;
  assign over           = bnn_prediction_i > CLS_BITS'(CLASS_CNT - 1);
  assign bnn_features_o = feat_q;
  assign bnn_rst_o      = rst_q;
  assign busy_o         = state_q != IDLE;
  assign bus.out_valid  = ov_q;
  assign bus.out_class  = cls_q;
  assign bus.out_err    = err_q;
`ifdef BNN_SEQ_PREFETCH_EN
  logic [FEAT_CNT*FEAT_BITS-1:0] buf_q;
  logic                          buf_v_q;
  assign bus.in_ready = armed_q & ((state_q == IDLE) | ~buf_v_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q   <= '0;
      buf_v_q <= 1'b0;
    end else if (give && state_q == HOLD) begin
      buf_v_q <= 1'b0;
    end else if (take && state_q != IDLE) begin
      buf_q   <= bus.in_features;
      buf_v_q <= 1'b1;
    end
`else
  assign bus.in_ready = armed_q & (state_q == IDLE);
`endif
  // CLEAR exits on cnt == CLEAR_CYCLES: the accepting cycle plus CLEAR_CYCLES full cycles of
  // reset with the new features applied, so out_valid lands CLEAR+SETTLE+1 edges after accept.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      feat_q  <= '0;
      rst_q   <= 1'b1;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      cls_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: if (take) begin
          feat_q  <= bus.in_features;
          cnt_q   <= '0;
          state_q <= CLEAR;
        end
        CLEAR: if (cnt_q == CW'(CLEAR_CYCLES)) begin
          cnt_q   <= '0;
          rst_q   <= 1'b0;
          state_q <= RUN;
        end else cnt_q <= cnt_q + CW'(1);
        RUN: if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cls_q   <= over ? CLS_BITS'(CLASS_CNT - 1) : bnn_prediction_i;
          err_q   <= over;
          ov_q    <= 1'b1;
          rst_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= HOLD;
        end else cnt_q <= cnt_q + CW'(1);
        HOLD: if (give) begin
          ov_q    <= 1'b0;
          state_q <= IDLE;
`ifdef BNN_SEQ_PREFETCH_EN
          if (buf_v_q || take) begin
            feat_q  <= buf_v_q ? buf_q : bus.in_features;
            state_q <= CLEAR;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bnn_infer_sequencer.sv
// tb_bnn_infer_sequencer: directed tests of the BNN sequencer with a stub / behavioural core.
module tb_bnn_infer_sequencer;
  localparam int FC = 12, FB = 4, CC = 6, CB = 3, FW = FC * FB;
`ifdef BNN_SEQ_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] bnn_features;
  logic          bnn_rst;
  logic          busy;
  logic [CB-1:0] bnn_prediction;
  logic [CB-1:0] stub_pred = '0;
  logic          stub_mode = 1'b0;
  int            core_cnt = 0;
  int            cyc = 0;
  int            errs = 0;
  int            checks = 0;
  bit            mon_en = 1'b0;
  logic [3:0]    got[$];
  bnn_infer_sequencer_if #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLS_BITS(CB)) bus();
  bnn_infer_sequencer #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bnn_features_o(bnn_features),
    .bnn_rst_o(bnn_rst), .bnn_prediction_i(bnn_prediction), .busy_o(busy));
  always #5 clk = ~clk;
  function automatic logic [2:0] core_f(input logic [FW-1:0] v);
    logic [3:0] x = '0;
    for (int i = 0; i < FC; i++) x ^= v[i*4 +: 4];
    return x[2:0];
  endfunction
  function automatic logic [3:0] gold(input logic [FW-1:0] v);
    logic [2:0] p = core_f(v);
    return p > 3'd5 ? 4'b1101 : {1'b0, p};
  endfunction
  // Behavioural core: prediction only becomes valid after 46 clocks out of reset.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    core_cnt <= bnn_rst ? 0 : core_cnt + 1;
    if (mon_en && bus.out_valid && bus.out_ready) got.push_back({bus.out_err, bus.out_class});
  end
  assign bnn_prediction = stub_mode ? (core_cnt >= 46 ? core_f(bnn_features) : 3'd0) : stub_pred;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [FW-1:0] v, output bit ok);
    bus.in_features = v;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask
  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bnn_rst !== 1'b1) begin errs++; $display("FAIL rst_bnn_rst got=%b exp=1", bnn_rst); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_class !== 3'd0 || bus.out_err !== 1'b0) begin
      errs++; $display("FAIL rst_out got=%b/%0d/%b exp=0/0/0", bus.out_valid, bus.out_class, bus.out_err); end
    checks++; if (busy !== 1'b0 || bnn_features !== '0) begin
      errs++; $display("FAIL rst_core got busy=%b feat=%h exp=0/0", busy, bnn_features); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rel_in_ready_early got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
  endtask
  task automatic test_basic();
    bit ok;
    bit stable = 1'b1;
    int lat = 0, lows = 0, highs = 0;
    stub_mode = 1'b0;
    stub_pred = 3'd3;
    send(48'h123456789ABC, ok);
    checks++; if (!ok) begin errs++; $display("FAIL basic_accept got=%b exp=1", ok); end
    checks++; if (bnn_features !== 48'h123456789ABC) begin errs++; $display("FAIL basic_feat got=%h exp=123456789abc", bnn_features); end
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
      if (bnn_rst === 1'b0) lows++;
      else if (lows == 0) highs++;
      if (bnn_features !== 48'h123456789ABC) stable = 1'b0;
    end
    checks++; if (highs != 1) begin errs++; $display("FAIL basic_clear_len got=%0d exp=1", highs); end
    checks++; if (lows != 47) begin errs++; $display("FAIL basic_run_len got=%0d exp=47", lows); end
    checks++; if (lat != 49) begin errs++; $display("FAIL basic_latency got=%0d exp=49", lat); end
    checks++; if (bus.out_class !== 3'd3 || bus.out_err !== 1'b0) begin
      errs++; $display("FAIL basic_result got=%0d/%b exp=3/0", bus.out_class, bus.out_err); end
    checks++; if (!stable) begin errs++; $display("FAIL basic_feat_stable got=0 exp=1"); end
  endtask
  task automatic test_hold_stall();
    bit stable = 1'b1;
    bus.out_ready = 1'b0;
    repeat (20) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_class !== 3'd3 || bus.out_err !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errs++; $display("FAIL stall_stable got=0 exp=1"); end
    checks++; if (bus.in_ready !== PF || busy !== 1'b1) begin
      errs++; $display("FAIL stall_state got rdy=%b busy=%b exp=%b/1", bus.in_ready, busy, PF); end
    handshake();
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL stall_release got v=%b busy=%b rdy=%b exp=0/0/1", bus.out_valid, busy, bus.in_ready); end
  endtask
  task automatic test_clamp();
    logic [2:0] tp[4] = '{3'd0, 3'd5, 3'd6, 3'd7};
    logic [2:0] tc[4] = '{3'd0, 3'd5, 3'd5, 3'd5};
    logic       te[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit ok;
    int lat;
    for (int i = 0; i < 4; i++) begin
      stub_pred = tp[i];
      send(48'h0F0F0F0F0F0F, ok);
      wait_valid(lat);
      checks++; if (!ok || lat != 49 || bus.out_class !== tc[i] || bus.out_err !== te[i]) begin
        errs++; $display("FAIL clamp_%0d got=%0d/%b lat=%0d exp=%0d/%b lat=49", tp[i], bus.out_class, bus.out_err, lat, tc[i], te[i]); end
      handshake();
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    int lat;
    stub_pred = 3'd2;
    send(48'hFEDCBA987654, ok);
    repeat (21) tick();
    checks++; if (bnn_rst !== 1'b0) begin errs++; $display("FAIL mid_running got=%b exp=0", bnn_rst); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bnn_rst !== 1'b1 || bus.out_valid !== 1'b0 || bnn_features !== '0) begin
      errs++; $display("FAIL mid_abort got rst=%b v=%b feat=%h exp=1/0/0", bnn_rst, bus.out_valid, bnn_features); end
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errs++; $display("FAIL mid_idle got busy=%b rdy=%b exp=0/0", busy, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send(48'h000000000001, ok);
    wait_valid(lat);
    checks++; if (!ok || lat != 49 || bus.out_class !== 3'd2 || bus.out_err !== 1'b0) begin
      errs++; $display("FAIL mid_recover got=%0d/%b lat=%0d exp=2/0 lat=49", bus.out_class, bus.out_err, lat); end
    handshake();
  endtask
  task automatic test_back_to_back();
    localparam int N = 30;
    logic [FW-1:0] vec[N];
    int acc[N];
    int bad = 0, w = 0;
    bit ok;
    stub_mode = 1'b1;
    bus.out_ready = 1'b1;
    got.delete();
    mon_en = 1'b1;
    for (int i = 0; i < N; i++) vec[i] = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < N; i++) begin
      send(vec[i], ok);
      acc[i] = cyc;
      if (!ok) bad++;
    end
    while (got.size() < N && w < 300) begin
      tick();
      w++;
    end
    checks++; if (bad != 0) begin errs++; $display("FAIL b2b_accept got=%0d rejected exp=0", bad); end
    checks++; if (got.size() != N) begin errs++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), N); end
    for (int i = 0; i < N && i < got.size(); i++) begin
      checks++; if (got[i] !== gold(vec[i])) begin
        errs++; $display("FAIL b2b_pred_%0d got=%h exp=%h", i, got[i], gold(vec[i])); end
    end
    if (!PF) begin
      bad = 0;
      for (int i = 1; i < N; i++) if (acc[i] - acc[i-1] != 51) bad++;
      checks++; if (bad != 0) begin errs++; $display("FAIL b2b_period got=%0d off-period exp=0", bad); end
    end
    mon_en = 1'b0;
    bus.out_ready = 1'b0;
    stub_mode = 1'b0;
    tick();
  endtask
`ifdef BNN_SEQ_PREFETCH_EN
  task automatic test_prefetch();
    bit ok;
    bit held = 1'b1;
    int lat = 0;
    stub_pred = 3'd1;
    bus.out_ready = 1'b0;
    send(48'hAAAAAAAAAAAA, ok);
    repeat (10) tick();
    send(48'hBBBBBBBBBBBB, ok);
    checks++; if (!ok || bnn_features !== 48'hAAAAAAAAAAAA) begin
      errs++; $display("FAIL pf_buffer got ok=%b feat=%h exp=1/aaaaaaaaaaaa", ok, bnn_features); end
    bus.in_features = 48'hCCCCCCCCCCCC;
    bus.in_valid = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) held = 1'b0;
      tick();
      lat++;
    end
    checks++; if (!held || bus.in_ready !== 1'b0) begin errs++; $display("FAIL pf_stall got rdy=%b exp=0", bus.in_ready); end
    handshake();
    checks++; if (bnn_features !== 48'hBBBBBBBBBBBB || busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL pf_switch got feat=%h busy=%b v=%b rdy=%b exp=bbbbbbbbbbbb/1/0/1", bnn_features, busy, bus.out_valid, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL pf_third got rdy=%b exp=0", bus.in_ready); end
    wait_valid(lat);
    checks++; if (lat != 48) begin errs++; $display("FAIL pf_latency got=%0d exp=48", lat); end
    handshake();
    checks++; if (bnn_features !== 48'hCCCCCCCCCCCC || busy !== 1'b1) begin
      errs++; $display("FAIL pf_third_load got feat=%h busy=%b exp=cccccccccccc/1", bnn_features, busy); end
    wait_valid(lat);
    handshake();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL pf_drain got busy=%b exp=0", busy); end
  endtask
`endif
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_features = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold_stall();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
`ifdef BNN_SEQ_PREFETCH_EN
    test_prefetch();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
